uart_tx_serial: RTL and testbench
=================================

// Module: uart_tx_serial
// PURPOSE
//   UART transmitter (8 data bits, no parity, STOP_BITS stop bits, LSB first) for the output side of the UART datapath.
//   Accepts a byte from the upstream producer (the averaging block drives TX_Data/TX_Data_Valid into TX_En_Sig).
//   Serialises the byte onto TX_Pin_Out and pulses TX_Done_Sig for one cycle so the producer drops its valid.
// PARAMETERS
//   CLK_FREQ   50_000_000  system clock frequency, Hz
//   BAUD_RATE  9600        line rate, bit/s; localparam BPS_CNT = CLK_FREQ/BAUD_RATE (integer divide, must be >= 2)
//   STOP_BITS  1           number of stop bits, legal values 1 or 2
// PORTS
//   CLK          input   1  system clock, all logic on rising edge
//   RSTn         input   1  synchronous reset, active-low
//   TX_En_Sig    input   1  level request: a byte is available on TX_Data
//   TX_Data      input   8  byte to send; sampled only at frame start
//   TX_Done_Sig  output  1  one-cycle pulse after the last stop bit completes
//   TX_Busy      output  1  high from frame start until the Done cycle, inclusive
//   TX_Pin_Out   output  1  serial line, idle high
// BEHAVIOUR
//   - Reset (RSTn low at a rising edge): state=IDLE, TX_Pin_Out=1, TX_Done_Sig=0, TX_Busy=0, baud count=0, bit index=0.
//     Reset mid-frame aborts the frame. The line returns high on that edge and no Done pulse is produced.
//   - FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> DONE -> IDLE.
//   - IDLE: TX_Pin_Out=1. If TX_En_Sig=1 at an edge:
//       latch TX_Data into the shift register, go to START, set TX_Busy=1.
//     The start bit appears on the line from the next cycle (latency 1 clock).
//   - The baud counter runs 0..BPS_CNT-1 in every non-IDLE, non-DONE state.
//     It clears on entering START. Each bit is held for exactly BPS_CNT cycles.
//     A bit ends at the edge where count==BPS_CNT-1.
//   - START: line=0 for one bit time.
//   - DATA: line=shift[idx], idx from 0 to 7, one bit time each.
//     Goes to PARITY (if enabled) or STOP after idx 7.
//   - STOP: line=1 for STOP_BITS bit times.
//   - DONE: lasts exactly 1 cycle. TX_Done_Sig=1, TX_Busy=1, line=1. Next state is IDLE.
//   - One frame per request: the producer clears its valid on the edge where it sees TX_Done_Sig.
//     So in the first IDLE cycle TX_En_Sig is already low and no repeat frame is sent.
//     If TX_En_Sig is still high in IDLE, a new frame starts (back-to-back; one idle-high cycle between frames).
//   - TX_Data and TX_En_Sig changes while busy are ignored.
//   - Frame length from start bit to last stop bit:
//       (1 + 8 + P + STOP_BITS) * BPS_CNT cycles, where P=1 with parity, else 0.
//     The Done pulse follows in the next cycle.
//   - All outputs are registered; no combinational path from inputs to outputs.
// CONFIGURATION
//   UART_TX_PARITY_EN defined: the PARITY state is inserted after DATA.
//     It lasts one bit time with line = ^TX_Data latched (even parity).
//   UART_TX_PARITY_EN undefined: no PARITY state and no parity logic; DATA goes straight to STOP.
// STRUCTURE
//   - Shared include uart_defs.vh:
//       state encodings (IDLE/START/DATA/PARITY/STOP/DONE, 3-bit);
//       a BPS_CNT helper macro/function;
//       the UART_TX_PARITY_EN default (left undefined).
//     The same include serves the receiver side.
//   - Sub-module uart_baud_tick:
//       parameter BPS_CNT; inputs CLK, RSTn, clear, enable; output tick, high when count==BPS_CNT-1.
//     The FSM, shift register and bit index stay in uart_tx_serial.
// TESTING (bench: CLK_FREQ=1_000_000, BAUD_RATE=100_000 -> BPS_CNT=10, STOP_BITS=1 unless stated)
//   1. Reset: hold RSTn=0 for 3 cycles with TX_En_Sig=1 -> TX_Pin_Out=1, TX_Done_Sig=0, TX_Busy=0 throughout.
//   2. Send 0x55 with a model producer that drops valid on Done:
//        line = 0,1,0,1,0,1,0,1,0,1, each level held exactly 10 cycles;
//        Done high for 1 cycle, 101 cycles after the request edge;
//        exactly one frame is sent.
//   3. STOP_BITS=2, send 0x00 -> 9 bit times low, then 20 cycles high, then Done; total 110 cycles.
//   4. Hold TX_En_Sig=1 continuously with 0xA3 then 0x3C ->
//        two frames separated by exactly one idle-high cycle after Done;
//        TX_Data changed mid-frame has no effect on the current frame.
//   5. Assert RSTn=0 during data bit 4 of 0xFF -> line=1 on the next edge, no Done; a new request afterwards sends a clean frame.
//   6. UART_TX_PARITY_EN defined:
//        0xA7 -> parity bit=1, frame 110 cycles, Done at +111;
//        0x03 -> parity bit=0.

Source files
------------

// File: rtl/uart_tx_serial_pkg.sv
// Shared UART definitions: FSM state encodings, baud divisor and parity helpers.
// Optional parity is selected by defining UART_TX_PARITY_EN (left undefined by default).
package uart_tx_serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5
  } tx_state_e;

  // Clock cycles per bit; integer divide, caller guarantees a result >= 2
  function automatic int unsigned calc_bps_cnt(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_tx_serial_baud_tick.sv
// Bit-time counter: counts 0..BPS_CNT-1 while enabled, tick marks the last cycle of a bit.
module uart_baud_tick #(
  parameter int unsigned BPS_CNT = 2
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CNT_W = (BPS_CNT > 2) ? $clog2(BPS_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BPS_CNT - 1);

  logic [CNT_W-1:0] cnt_r;

  // Wrapping bit-time counter; clear has priority over counting
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (enable) begin
      if (cnt_r == CNT_MAX) begin
        cnt_r <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + CNT_W'(1'b1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tick = (cnt_r == CNT_MAX);

endmodule

// File: rtl/uart_tx_serial.sv
// UART transmitter, 8N1/8N2 LSB first, one frame per request with a one-cycle Done pulse.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop bits.
module uart_tx_serial
  import uart_tx_serial_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       TX_En_Sig,
  input  logic [7:0] TX_Data,
  output logic       TX_Done_Sig,
  output logic       TX_Busy,
  output logic       TX_Pin_Out
);

  localparam int unsigned BPS_CNT = calc_bps_cnt(CLK_FREQ, BAUD_RATE);
  localparam logic STOP_LAST = (STOP_BITS == 32'd2) ? 1'b1 : 1'b0;

  tx_state_e  state_r;
  logic [7:0] shift_r;
  logic [2:0] bit_idx_r;
  logic       stop_idx_r;
  logic       done_r;
  logic       busy_r;
  logic       pin_r;
  logic       tick_s;
  logic       cnt_clear_s;
  logic       cnt_en_s;
`ifdef UART_TX_PARITY_EN
  logic       parity_r;
`endif

  assign cnt_clear_s = (state_r == ST_IDLE) && TX_En_Sig;
  assign cnt_en_s    = (state_r != ST_IDLE) && (state_r != ST_DONE);

  uart_baud_tick #(
    .BPS_CNT (BPS_CNT)
  ) u_baud_tick (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .clear  (cnt_clear_s),
    .enable (cnt_en_s),
    .tick   (tick_s)
  );

  // Frame FSM; outputs are registered alongside the transition so the line leads the state by nothing
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_r    <= ST_IDLE;
      shift_r    <= 8'h00;
      bit_idx_r  <= 3'd0;
      stop_idx_r <= 1'b0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
      pin_r      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (TX_En_Sig) begin
            shift_r    <= TX_Data;
`ifdef UART_TX_PARITY_EN
            parity_r   <= even_parity(TX_Data);
`endif
            bit_idx_r  <= 3'd0;
            stop_idx_r <= 1'b0;
            busy_r     <= 1'b1;
            pin_r      <= 1'b0;
            state_r    <= ST_START;
          end else begin
            busy_r <= 1'b0;
            pin_r  <= 1'b1;
          end
        end
        ST_START: begin
          if (tick_s) begin
            pin_r   <= shift_r[0];
            state_r <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick_s) begin
            if (bit_idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              pin_r   <= parity_r;
              state_r <= ST_PARITY;
`else
              pin_r   <= 1'b1;
              state_r <= ST_STOP;
`endif
            end else begin
              // shift_r[0] is already on the line, so the next bit sits at index 1
              bit_idx_r <= bit_idx_r + 3'd1;
              shift_r   <= {1'b0, shift_r[7:1]};
              pin_r     <= shift_r[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (tick_s) begin
            pin_r   <= 1'b1;
            state_r <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (tick_s) begin
            if (stop_idx_r == STOP_LAST) begin
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              stop_idx_r <= stop_idx_r + 1'b1;
            end
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          pin_r   <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          pin_r   <= 1'b1;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign TX_Done_Sig = done_r;
  assign TX_Busy     = busy_r;
  assign TX_Pin_Out  = pin_r;

endmodule

// File: tb/tb_uart_tx_serial.sv
// Bench for uart_tx_serial: two instances (1 and 2 stop bits), per-cycle line scoreboard.
// Define UART_TX_PARITY_EN for the parity build; expected frames then carry the parity bit.
module tb_uart_tx_serial;

  localparam int unsigned CLK_FREQ = 1_000_000;
  localparam int unsigned BAUD     = 100_000;
  localparam int          BPS      = 10;
`ifdef UART_TX_PARITY_EN
  localparam int          PAR      = 1;
`else
  localparam int          PAR      = 0;
`endif

  logic       CLK;
  logic       RSTn;
  logic       en1, en2;
  logic [7:0] d1, d2;
  logic       done1, busy1, pin1;
  logic       done2, busy2, pin2;

  int   n_assert = 0;
  int   n_fail   = 0;
  logic exp_q[$];

  uart_tx_serial #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .STOP_BITS(1)) dut1 (
    .CLK(CLK), .RSTn(RSTn), .TX_En_Sig(en1), .TX_Data(d1),
    .TX_Done_Sig(done1), .TX_Busy(busy1), .TX_Pin_Out(pin1)
  );

  uart_tx_serial #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .STOP_BITS(2)) dut2 (
    .CLK(CLK), .RSTn(RSTn), .TX_En_Sig(en2), .TX_Data(d2),
    .TX_Done_Sig(done2), .TX_Busy(busy2), .TX_Pin_Out(pin2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic pin_of(input int sel);
    return (sel == 2) ? pin2 : pin1;
  endfunction
  function automatic logic busy_of(input int sel);
    return (sel == 2) ? busy2 : busy1;
  endfunction
  function automatic logic done_of(input int sel);
    return (sel == 2) ? done2 : done1;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Expected line level for every cycle of one frame
  task automatic push_frame(input logic [7:0] d, input int nstop);
    repeat (BPS) exp_q.push_back(1'b0);
    for (int b = 0; b < 8; b++) repeat (BPS) exp_q.push_back(d[b]);
    if (PAR == 1) repeat (BPS) exp_q.push_back(^d);
    repeat (nstop * BPS) exp_q.push_back(1'b1);
  endtask

  // Request must have been raised before the coming posedge; checks every cycle then the Done cycle
  task automatic check_frame(input int sel, input string tag, input int chg_at,
                             input logic [7:0] chg_d, input bit drop);
    int   c = 0;
    logic e;
    while (exp_q.size() > 0) begin
      @(negedge CLK);
      e = exp_q.pop_front();
      chk({tag, "_line"}, pin_of(sel), e);
      chk({tag, "_busy"}, busy_of(sel), 1'b1);
      chk({tag, "_early_done"}, done_of(sel), 1'b0);
      if (c == chg_at) begin
        if (sel == 2) d2 = chg_d; else d1 = chg_d;
      end
      c++;
    end
    @(negedge CLK);
    chk({tag, "_done"}, done_of(sel), 1'b1);
    chk({tag, "_done_busy"}, busy_of(sel), 1'b1);
    chk({tag, "_done_line"}, pin_of(sel), 1'b1);
    if (drop) begin
      if (sel == 2) en2 = 1'b0; else en1 = 1'b0;
    end
  endtask

  task automatic idle_chk(input int sel, input string tag, input int n);
    repeat (n) begin
      @(negedge CLK);
      chk({tag, "_line"}, pin_of(sel), 1'b1);
      chk({tag, "_busy"}, busy_of(sel), 1'b0);
      chk({tag, "_done"}, done_of(sel), 1'b0);
    end
  endtask

  initial begin
    int   seen;
    logic e;

    // Reset held with a pending request on both instances
    RSTn = 1'b0; en1 = 1'b1; en2 = 1'b1; d1 = 8'h55; d2 = 8'h00;
    repeat (3) begin
      @(negedge CLK);
      chk("rst_line1", pin1, 1'b1);
      chk("rst_done1", done1, 1'b0);
      chk("rst_busy1", busy1, 1'b0);
      chk("rst_line2", pin2, 1'b1);
      chk("rst_done2", done2, 1'b0);
      chk("rst_busy2", busy2, 1'b0);
    end
    en1 = 1'b0; en2 = 1'b0; RSTn = 1'b1;
    idle_chk(1, "post_rst1", 2);
    idle_chk(2, "post_rst2", 1);

    // 0x55 with a producer that drops valid on Done; no repeat frame
    d1 = 8'h55; en1 = 1'b1;
    push_frame(8'h55, 1);
    check_frame(1, "t2", -1, 8'h00, 1'b1);
    idle_chk(1, "t2_once", 20);

    // Two stop bits, 0x00
    d2 = 8'h00; en2 = 1'b1;
    push_frame(8'h00, 2);
    check_frame(2, "t3", -1, 8'h00, 1'b1);
    idle_chk(2, "t3_idle", 3);

    // Back-to-back with valid held; data changes mid-frame
    d1 = 8'hA3; en1 = 1'b1;
    push_frame(8'hA3, 1);
    check_frame(1, "t4a", 30, 8'h3C, 1'b0);
    idle_chk(1, "t4_gap", 1);
    push_frame(8'h3C, 1);
    check_frame(1, "t4b", 45, 8'h81, 1'b1);
    idle_chk(1, "t4_end", 5);

    // Reset during data bit 4 of 0xFF
    d1 = 8'hFF; en1 = 1'b1;
    push_frame(8'hFF, 1);
    for (int c = 0; c < 55; c++) begin
      @(negedge CLK);
      e = exp_q.pop_front();
      chk("t5_pre_line", pin1, e);
    end
    RSTn = 1'b0; en1 = 1'b0;
    @(negedge CLK);
    chk("t5_abort_line", pin1, 1'b1);
    chk("t5_abort_busy", busy1, 1'b0);
    chk("t5_abort_done", done1, 1'b0);
    RSTn = 1'b1;
    exp_q.delete();
    seen = 0;
    repeat (120) begin
      @(negedge CLK);
      if (done1 !== 1'b0 || pin1 !== 1'b1) seen++;
    end
    chk("t5_quiet", (seen == 0), 1'b1);
    d1 = 8'h5A; en1 = 1'b1;
    push_frame(8'h5A, 1);
    check_frame(1, "t5_clean", -1, 8'h00, 1'b1);
    idle_chk(1, "t5_idle", 2);

`ifdef UART_TX_PARITY_EN
    // Parity frames: 0xA7 odd weight (bit 1), 0x03 even weight (bit 0)
    d1 = 8'hA7; en1 = 1'b1;
    push_frame(8'hA7, 1);
    check_frame(1, "t6_a7", -1, 8'h00, 1'b1);
    idle_chk(1, "t6_idle1", 2);
    d1 = 8'h03; en1 = 1'b1;
    push_frame(8'h03, 1);
    check_frame(1, "t6_03", -1, 8'h00, 1'b1);
    idle_chk(1, "t6_idle2", 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
